// File: rtl/ocx_tlx_resp_fifo_mac.sv
// ocx_tlx_resp_fifo_mac
// Transmit-side AFU response queue for the TLX. AFU responses arrive under
// TLX-to-AFU response credits and are buffered in a circular FIFO. The head
// entry is presented first-word fall-through to the transmit framer. It is
// only offered while the host has VC0 TL credit available.
//
// Ports
//   tlx_clk, reset_n               clock, synchronous active-low reset
//   afu_tlx_resp_*                 AFU response write (valid + fields)
//   tlx_afu_resp_credit            one-cycle credit return pulse to the AFU
//   tlx_afu_resp_initial_credit    constant DEPTH
//   rcv_xmt_tl_credit_vc0_valid/   host VC0 credit return (count 0..15)
//   rcv_xmt_tl_credit_vc0
//   xmt_resp_rd_req                framer pop request
//   xmt_resp_valid/xmt_resp_data   head entry offered to the framer
//   xmt_resp_empty                 FIFO occupancy == 0
//   host_vc0_credit_cnt            current host VC0 credit count
//   resp_fifo_error                sticky {credit overflow, bad pop, write while full}
//
// Handshake: the framer pops the head in any cycle where xmt_resp_valid and
// xmt_resp_rd_req are both high. A request while valid is low has no effect
// on the data path and only sets the sticky error bit. The AFU writes one
// entry per cycle with afu_tlx_resp_valid. There is no back-pressure: a
// write with no free slot and no simultaneous pop is dropped.

module ocx_tlx_resp_fifo_mac #(
  parameter int resp_addr_width = 4
) (
  input  logic        tlx_clk,
  input  logic        reset_n,
  input  logic        afu_tlx_resp_valid,
  input  logic [7:0]  afu_tlx_resp_opcode,
  input  logic [1:0]  afu_tlx_resp_dl,
  input  logic [15:0] afu_tlx_resp_capptag,
  input  logic [1:0]  afu_tlx_resp_dp,
  input  logic [3:0]  afu_tlx_resp_code,
  output logic        tlx_afu_resp_credit,
  output logic [6:0]  tlx_afu_resp_initial_credit,
  input  logic        rcv_xmt_tl_credit_vc0_valid,
  input  logic [3:0]  rcv_xmt_tl_credit_vc0,
  input  logic        xmt_resp_rd_req,
  output logic        xmt_resp_valid,
  output logic [31:0] xmt_resp_data,
  output logic        xmt_resp_empty,
  output logic [7:0]  host_vc0_credit_cnt,
  output logic [2:0]  resp_fifo_error
);

  localparam int DEPTH = 1 << resp_addr_width;
  localparam logic [resp_addr_width:0] FULL_OCC = (resp_addr_width + 1)'(DEPTH);

  logic [31:0]                resp_mem [DEPTH];
  logic [resp_addr_width-1:0] wr_ptr;
  logic [resp_addr_width-1:0] rd_ptr;
  logic [resp_addr_width:0]   occupancy;

  logic       fifo_full;
  logic       pop_accepted;
  logic       wr_accepted;
  logic       wr_dropped;
  logic       bad_pop;
  logic [3:0] host_return;
  logic [8:0] host_sum;
  logic       host_overflow;
  logic [7:0] host_next;
  logic [31:0] wr_entry;

  assign tlx_afu_resp_initial_credit = 7'(DEPTH);

  assign fifo_full      = (occupancy == FULL_OCC);
  assign xmt_resp_empty = (occupancy == '0);
  assign xmt_resp_valid = !xmt_resp_empty && (host_vc0_credit_cnt != 8'd0);
  assign xmt_resp_data  = resp_mem[rd_ptr];

  assign pop_accepted = xmt_resp_rd_req && xmt_resp_valid;
  assign bad_pop      = xmt_resp_rd_req && !xmt_resp_valid;
  // A pop in the same cycle frees the head slot, so a full FIFO can still
  // take a write.
  assign wr_accepted  = afu_tlx_resp_valid && (!fifo_full || pop_accepted);
  assign wr_dropped   = afu_tlx_resp_valid && !wr_accepted;

  assign wr_entry = {afu_tlx_resp_code, afu_tlx_resp_dp, afu_tlx_resp_capptag,
                     afu_tlx_resp_dl, afu_tlx_resp_opcode};

  // The 9-bit sum cannot underflow because a pop needs a nonzero count.
  assign host_return   = rcv_xmt_tl_credit_vc0_valid ? rcv_xmt_tl_credit_vc0 : 4'd0;
  assign host_sum      = {1'b0, host_vc0_credit_cnt} + {5'd0, host_return}
                       - {8'd0, pop_accepted};
  assign host_overflow = host_sum[8];
  assign host_next     = host_overflow ? 8'hff : host_sum[7:0];

  // Storage has no reset; its contents only matter where occupancy covers them.
  always_ff @(posedge tlx_clk) begin
    if (wr_accepted) begin
      resp_mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge tlx_clk) begin
    if (!reset_n) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      occupancy           <= '0;
      host_vc0_credit_cnt <= 8'd0;
      resp_fifo_error     <= 3'b000;
      tlx_afu_resp_credit <= 1'b0;
    end else begin
      if (wr_accepted) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_accepted) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_accepted, pop_accepted})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      host_vc0_credit_cnt <= host_next;
      resp_fifo_error     <= resp_fifo_error | {host_overflow, bad_pop, wr_dropped};
      tlx_afu_resp_credit <= pop_accepted;
    end
  end

endmodule

// File: doc/ocx_tlx_resp_fifo_mac.md
Name: ocx_tlx_resp_fifo_mac

Overview:
- Transmit-side AFU response queue for the TLX.
- Accepts AFU responses under TLX-to-AFU response credits and buffers them in a circular FIFO.
- Presents the head entry, first-word fall-through, to the transmit framer, gated by a host VC0 TL credit counter.
- Mirrors the receive command FIFO: AFU→host responses instead of host→AFU commands.

Parameters:
- resp_addr_width, 4: FIFO address width. DEPTH = 2**resp_addr_width entries, each 32 bits wide.

Ports:
- tlx_clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- afu_tlx_resp_valid  in  1  AFU response write strobe, one entry per cycle.
- afu_tlx_resp_opcode  in  8  response opcode.
- afu_tlx_resp_dl  in  2  data length.
- afu_tlx_resp_capptag  in  16  CAPP tag.
- afu_tlx_resp_dp  in  2  data part.
- afu_tlx_resp_code  in  4  response code.
- tlx_afu_resp_credit  out  1  one-cycle pulse returning one response credit to the AFU.
- tlx_afu_resp_initial_credit  out  7  constant DEPTH.
- rcv_xmt_tl_credit_vc0_valid  in  1  host VC0 credit return valid.
- rcv_xmt_tl_credit_vc0  in  4  number of credits returned (0–15).
- xmt_resp_rd_req  in  1  framer pops the head entry.
- xmt_resp_valid  out  1  head entry available and host credit available.
- xmt_resp_data  out  32  head entry, packed as {code[31:28], dp[27:26], capptag[25:10], dl[9:8], opcode[7:0]}.
- xmt_resp_empty  out  1  FIFO occupancy == 0.
- host_vc0_credit_cnt  out  8  current host VC0 credit count.
- resp_fifo_error  out  3  sticky flags: [0] write while full, [1] pop while not valid, [2] host credit counter overflow.

Behaviour:
- Reset: reset is synchronous and active-low; tlx_clk is the only clock. On the reset cycle:
  - write pointer, read pointer, occupancy, host_vc0_credit_cnt and resp_fifo_error all clear to 0;
  - tlx_afu_resp_credit = 0, xmt_resp_valid = 0, xmt_resp_empty = 1;
  - storage contents are don't-care.
- Reset mid-operation: all in-flight entries and credits are discarded.
- Initial credit: tlx_afu_resp_initial_credit is a constant 7-bit value of DEPTH (16 at the default). It is valid whenever reset_n = 1.
- Write path:
  - afu_tlx_resp_valid = 1 and (occupancy < DEPTH, or an accepted pop in the same cycle) → entry written at the write pointer; the write pointer increments modulo DEPTH.
  - Write while full with no pop → entry dropped, error[0] set, pointers unchanged.
- Read path, first-word fall-through:
  - xmt_resp_data = storage[read pointer], combinational.
  - xmt_resp_valid = (occupancy != 0) & (host_vc0_credit_cnt != 0).
  - Write-to-valid latency is 1 cycle: an entry written in cycle N is visible in cycle N+1.
  - Accepted pop = xmt_resp_rd_req & xmt_resp_valid. It advances the read pointer modulo DEPTH and decrements the host count by 1.
  - xmt_resp_rd_req while not valid → ignored and error[1] set.
- Occupancy: next = occupancy + write_accepted − pop_accepted. Width is resp_addr_width+1, so full is occupancy == DEPTH.
- AFU credit return: tlx_afu_resp_credit is a registered copy of pop_accepted, i.e. it pulses 1 cycle after each accepted pop.
- Host credit counter:
  - next = cnt + (rcv_xmt_tl_credit_vc0_valid ? rcv_xmt_tl_credit_vc0 : 0) − pop_accepted.
  - Arithmetic is 9-bit; a result > 255 saturates to 255 and sets error[2].
  - A return and a pop in the same cycle are both applied.
  - The count cannot go below 0 because a pop requires cnt != 0.
- Errors: resp_fifo_error bits are sticky until reset; the data path keeps running after an error.
- Wrap-around: pointers wrap from DEPTH−1 to 0 with no bubble.

Test Plan:
- Reset, then 4 idle cycles → tlx_afu_resp_initial_credit = 16, xmt_resp_empty = 1, xmt_resp_valid = 0, tlx_afu_resp_credit = 0, error = 0, host_vc0_credit_cnt = 0.
- Write 16 entries (capptag 0..15) with no host credit → xmt_resp_valid stays 0 and occupancy reaches 16. Then return 3 host credits with rd_req held high → exactly 3 pops of capptag 0, 1, 2, three tlx_afu_resp_credit pulses each 1 cycle after its pop, then valid drops and count = 0.
- FIFO full plus a 17th write with no pop → entry dropped, error[0] = 1. Same 17th write coincident with an accepted pop → entry accepted, error[0] = 0.
- Host returns 15 credits for 18 cycles (270 total) → count saturates at 255 and error[2] = 1. A return of 2 coincident with a pop at count 10 → count = 11.
- Stream 40 entries with continuous write, credit and pop → output order equals input order across two pointer wraps, and there are 40 AFU credit pulses.
- Assert reset_n = 0 for 1 cycle with 5 entries queued and 4 credits → next cycle occupancy = 0, count = 0, xmt_resp_valid = 0. A following write/pop sequence is correct; rd_req on empty sets error[1].
